// File: rtl/demux4_router_pkg.sv
// Shared constants and types for the 1-to-4 registered demultiplexer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents:
//   NOUT, SEL_W, STAT_W  lane count, select width, per-lane stat counter width
//   lane_state_t         one-entry lane buffer state (EMPTY / FULL)
//   sel_onehot()         binary lane select -> one-hot lane vector
package demux4_router_pkg;

    localparam int NOUT   = 4;
    localparam int SEL_W  = 2;
    localparam int STAT_W = 8;

    // A lane is a single-entry buffer, so one state bit is enough.
    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

    function automatic logic [NOUT-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NOUT-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux4_router_lane.sv
// One lane of the demultiplexer: a one-entry holding buffer with its own FSM.
// Latency: word written on wr_en is presented on data/full the next cycle.
// Backpressure: holds word while rd_ready=0; caller must only write when !full or rd_ready.
//
// Build option: DEMUX_STATS_EN adds a saturating accept counter (stat_cnt).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en        write wr_data into the buffer this cycle
//   wr_data      word to store
//   rd_ready     consumer takes the buffered word this cycle (when full)
//   full         buffer holds a word (lane out_valid)
//   data         buffered word (lane out_data), held until the next write
//   stat_cnt     accepts seen by this lane, saturating (DEMUX_STATS_EN only)
module demux_lane
    import demux4_router_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_ready,
    output logic              full,
    output logic [WIDTH-1:0]  data
`ifdef DEMUX_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_cnt
`endif
);

    lane_state_t      state;
    logic [WIDTH-1:0] data_q;

    // A write on a FULL lane is only issued by the top when the consumer is
    // draining the same cycle, so the new word simply replaces the old one
    // and the lane stays FULL with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LANE_EMPTY;
            data_q <= '0;
        end else begin
            case (state)
                LANE_EMPTY: begin
                    if (wr_en) begin
                        state  <= LANE_FULL;
                        data_q <= wr_data;
                    end
                end
                LANE_FULL: begin
                    if (wr_en) begin
                        data_q <= wr_data;
                    end else if (rd_ready) begin
                        state <= LANE_EMPTY;
                    end
                end
            endcase
        end
    end

    // Straight decode of the state flop: no combinational path from inputs,
    // so out_valid drops the instant reset is asserted.
    assign full = (state == LANE_FULL);
    // data_q is only written on accept, so an EMPTY lane keeps its last word.
    assign data = data_q;

`ifdef DEMUX_STATS_EN
    logic [STAT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (wr_en && (cnt_q != {STAT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stat_cnt = cnt_q;
`endif

endmodule

// File: rtl/demux4_router.sv
// 1-to-4 registered demultiplexer: routes one word per cycle into a one-entry buffer on the selected lane.
// Latency: 1 cycle from accept to out_valid on the destination lane.
// Backpressure: in_ready = lane empty or draining this cycle; a stalled lane never blocks other lanes.
//
// Build option: DEMUX_STATS_EN adds per-lane 8-bit saturating accept counters on stat_cnt.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     producer has a word on in_data
//   in_ready     router accepts the word this cycle (independent of in_valid)
//   in_data      word to route
//   in_sel       destination lane 0..3
//   out_valid    bit k: lane k buffer holds a word
//   out_ready    bit k: consumer k takes the word this cycle
//   out_data     lane k word at [k*WIDTH +: WIDTH]
//   stat_cnt     lane k accept count at [k*8 +: 8] (DEMUX_STATS_EN only)
module demux4_router
    import demux4_router_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [NOUT-1:0]        out_valid,
    input  logic [NOUT-1:0]        out_ready,
    output logic [NOUT*WIDTH-1:0]  out_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [NOUT*STAT_W-1:0] stat_cnt
`endif
);

    logic [NOUT-1:0] lane_full;
    logic [NOUT-1:0] lane_wr;
    logic            accept;

    // Only the addressed lane's state gates the input, which is what keeps
    // a stalled consumer from blocking traffic headed elsewhere.
    assign in_ready = ~lane_full[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;
    assign lane_wr  = sel_onehot(in_sel) & {NOUT{accept}};

    assign out_valid = lane_full;

    for (genvar k = 0; k < NOUT; k++) begin : g_lane
        demux_lane #(
            .WIDTH   (WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (lane_wr[k]),
            .wr_data  (in_data),
            .rd_ready (out_ready[k]),
            .full     (lane_full[k]),
            .data     (out_data[k*WIDTH +: WIDTH])
`ifdef DEMUX_STATS_EN
            ,
            .stat_cnt (stat_cnt[k*STAT_W +: STAT_W])
`endif
        );
    end

endmodule
